// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide unit.
// The EX stage drives the request side; the unit returns HI, LO and busy.
interface hilo_muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    modport master (
        output start, op, a, b,
        input  hi, lo, busy
    );

    modport slave (
        input  start, op, a, b,
        output hi, lo, busy
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// The result is computed at accept time and committed after a fixed latency.
module hilo_muldiv #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic          clk,
    input  logic          rst,
    hilo_muldiv_if.slave  bus
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [31:0]       hi_r, hi_s;
    logic [31:0]       lo_r, lo_s;
    logic              busy_r, busy_s;
    logic [31:0]       pend_hi_r, pend_hi_s;
    logic [31:0]       pend_lo_r, pend_lo_s;
    logic              pend_wr_r, pend_wr_s;

    logic signed [63:0] smul_s;
    logic [63:0]        umul_s;
    logic [31:0]        a_mag_s, b_mag_s;
    logic [31:0]        q_mag_s, r_mag_s;
    logic [31:0]        sdiv_q_s, sdiv_r_s;
    logic [31:0]        udiv_q_s, udiv_r_s;
    logic               b_zero_s;

    // Arithmetic datapath evaluated on the live operands; only sampled on accept.
    always_comb begin
        smul_s   = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
        umul_s   = {32'd0, bus.a} * {32'd0, bus.b};
        b_zero_s = (bus.b == 32'd0);
        a_mag_s  = bus.a[31] ? (32'd0 - bus.a) : bus.a;
        b_mag_s  = bus.b[31] ? (32'd0 - bus.b) : bus.b;
        // Signed divide through magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
        if (b_zero_s) begin
            q_mag_s  = 32'd0;
            r_mag_s  = 32'd0;
            udiv_q_s = 32'd0;
            udiv_r_s = 32'd0;
        end else begin
            q_mag_s  = a_mag_s / b_mag_s;
            r_mag_s  = a_mag_s % b_mag_s;
            udiv_q_s = bus.a / bus.b;
            udiv_r_s = bus.a % bus.b;
        end
        sdiv_q_s = (bus.a[31] ^ bus.b[31]) ? (32'd0 - q_mag_s) : q_mag_s;
        sdiv_r_s = bus.a[31] ? (32'd0 - r_mag_s) : r_mag_s;
    end

    // Next-state, counter, pending result and HI/LO update.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        busy_s    = busy_r;
        pend_hi_s = pend_hi_r;
        pend_lo_s = pend_lo_r;
        pend_wr_s = pend_wr_r;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT: begin
                            pend_hi_s = smul_s[63:32];
                            pend_lo_s = smul_s[31:0];
                            pend_wr_s = 1'b1;
                            cnt_s     = MULT_LOAD;
                            state_s   = ST_RUN;
                            busy_s    = 1'b1;
                        end
                        OP_MULTU: begin
                            pend_hi_s = umul_s[63:32];
                            pend_lo_s = umul_s[31:0];
                            pend_wr_s = 1'b1;
                            cnt_s     = MULT_LOAD;
                            state_s   = ST_RUN;
                            busy_s    = 1'b1;
                        end
                        OP_DIV: begin
                            pend_hi_s = sdiv_r_s;
                            pend_lo_s = sdiv_q_s;
                            pend_wr_s = ~b_zero_s;
                            cnt_s     = DIV_LOAD;
                            state_s   = ST_RUN;
                            busy_s    = 1'b1;
                        end
                        OP_DIVU: begin
                            pend_hi_s = udiv_r_s;
                            pend_lo_s = udiv_q_s;
                            pend_wr_s = ~b_zero_s;
                            cnt_s     = DIV_LOAD;
                            state_s   = ST_RUN;
                            busy_s    = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_s = bus.a;
                        end
                        OP_MTLO: begin
                            lo_s = bus.a;
                        end
                        default: begin
                            state_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Any start seen here is a hazard-unit escape; it is deliberately dropped.
                if (cnt_r == CNT_ZERO) begin
                    if (pend_wr_r) begin
                        hi_s = pend_hi_r;
                        lo_s = pend_lo_r;
                    end else begin
                        hi_s = hi_r;
                        lo_s = lo_r;
                    end
                    pend_wr_s = 1'b0;
                    busy_s    = 1'b0;
                    state_s   = ST_IDLE;
                end else begin
                    cnt_s  = cnt_r - CNT_ONE;
                    busy_s = 1'b1;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                busy_s    = 1'b0;
                pend_wr_s = 1'b0;
                cnt_s     = CNT_ZERO;
            end
        endcase
    end

    // State and architectural registers; rst overrides everything on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            pend_wr_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            busy_r    <= busy_s;
            pend_hi_r <= pend_hi_s;
            pend_lo_r <= pend_lo_s;
            pend_wr_r <= pend_wr_s;
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: expected HI/LO and busy length are queued at issue
// and popped when the unit drops busy.
module tb_hilo_muldiv;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t sb[$];

    hilo_muldiv_if bus ();

    hilo_muldiv #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Issue one op at the next edge, then follow busy until it drops and score the result.
    task automatic run_op(input string tag, input logic [2:0] op_v, input logic [31:0] a_v,
                          input logic [31:0] b_v, input logic [31:0] eh, input logic [31:0] el,
                          input int n);
        logic [31:0] hi0;
        logic [31:0] lo0;
        exp_t        e;
        int          cnt;
        hi0 = bus.hi;
        lo0 = bus.lo;
        sb.push_back('{eh, el, n});
        bus.start = 1'b1;
        bus.op    = op_v;
        bus.a     = a_v;
        bus.b     = b_v;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 32'hDEADBEEF;
        bus.b     = 32'h0000_0000;
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            if (cnt == 1) begin
                check_val({tag, " hi_hold"}, bus.hi, hi0);
                check_val({tag, " lo_hold"}, bus.lo, lo0);
            end
            @(negedge clk);
        end
        e = sb.pop_front();
        check_val({tag, " busy_cycles"}, cnt, e.cycles);
        check_val({tag, " hi"}, bus.hi, e.hi);
        check_val({tag, " lo"}, bus.lo, e.lo);
    endtask

    initial begin
        int cnt;
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("reset hi", bus.hi, 32'd0);
        check_val("reset lo", bus.lo, 32'd0);
        check_val("reset busy", {31'd0, bus.busy}, 32'd0);

        run_op("mult",  3'b000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        run_op("multu", 3'b001, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5);
        run_op("div",   3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        run_op("divu",  3'b011, 32'd7,        32'd2, 32'h00000001, 32'h00000003, 10);
        run_op("mthi",  3'b100, 32'h00000011, 32'd0, 32'h00000011, 32'h00000003, 0);
        run_op("mtlo",  3'b101, 32'h00000022, 32'd0, 32'h00000011, 32'h00000022, 0);
        run_op("divu0", 3'b011, 32'd5,        32'd0, 32'h00000011, 32'h00000022, 10);
        run_op("mthi2", 3'b100, 32'h0000ABCD, 32'd0, 32'h0000ABCD, 32'h00000022, 0);
        run_op("undef", 3'b110, 32'h55555555, 32'd1, 32'h0000ABCD, 32'h00000022, 0);
        run_op("divovf", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
        run_op("divneg", 3'b010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);

        // mult with a div start injected mid-run: the div must be ignored.
        sb.push_back('{32'h00000012, 32'h34567800, 5});
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'h12345678;
        bus.b     = 32'h00000100;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 32'h0BADF00D;
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            if (cnt == 2) begin
                bus.start = 1'b1;
                bus.op    = 3'b010;
                bus.a     = 32'd9;
                bus.b     = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        begin
            exp_t e;
            e = sb.pop_front();
            check_val("inject busy_cycles", cnt, e.cycles);
            check_val("inject hi", bus.hi, e.hi);
            check_val("inject lo", bus.lo, e.lo);
        end
        repeat (3) @(negedge clk);
        check_val("inject no_div busy", {31'd0, bus.busy}, 32'd0);
        check_val("inject no_div lo", bus.lo, 32'h34567800);

        // Same again but rst lands mid-run: result must never appear.
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd7;
        bus.b     = 32'd6;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 3) begin
            cnt++;
            if (cnt == 3) begin
                rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        check_val("abort hi", bus.hi, 32'd0);
        check_val("abort lo", bus.lo, 32'd0);
        check_val("abort busy", {31'd0, bus.busy}, 32'd0);
        repeat (8) @(negedge clk);
        check_val("abort late lo", bus.lo, 32'd0);
        check_val("abort late busy", {31'd0, bus.busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
